serial_addsub: RTL and testbench

Parametrised multi-cycle adder/subtractor. It processes DIGIT bits per clock, LSB first, through a registered carry, so the add costs one DIGIT-wide full-adder slice instead of a WIDTH-wide ripple.
- Adds a subtract mode, a start/busy/done handshake, and carry-out and signed-overflow flags.
- Sits behind the top-level I/O wrapper: operands are loaded in parallel and the result is read back in parallel.

---
 rtl/serial_addsub_pkg.sv | 15 +
 rtl/addsub_digit.sv | 27 ++
 rtl/serial_addsub.sv | 103 ++++++++++
 tb/tb_serial_addsub.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_addsub_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // One extra bit so that a single-digit configuration still gets a 1-bit counter.
  function automatic int unsigned cnt_width(input int unsigned ndig);
    return $clog2(ndig) + 1;
  endfunction

endpackage

// File: rtl/addsub_digit.sv
// DIGIT-wide ripple slice of 1-bit full adders; also exposes the carry into its top bit.
module addsub_digit #(
  parameter int unsigned DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  logic c;

  always_comb begin
    s     = '0;
    c     = cin;
    c_msb = cin;
    for (int i = 0; i < int'(DIGIT); i++) begin
      c_msb = c;
      s[i]  = x[i] ^ y[i] ^ c;
      c     = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/serial_addsub.sv
// Multi-cycle adder/subtractor: DIGIT bits per clock, LSB first, through a registered carry.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned CW   = cnt_width(NDIG);

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [DIGIT-1:0] slice_s;
  logic             slice_cout;
  logic             slice_cmsb;
  logic [WIDTH-1:0] acc_next;

  addsub_digit #(
    .DIGIT(DIGIT)
  ) u_digit (
    .x    (op_a[DIGIT-1:0]),
    .y    (op_b[DIGIT-1:0]),
    .cin  (carry),
    .s    (slice_s),
    .cout (slice_cout),
    .c_msb(slice_cmsb)
  );

  // New digit enters at the top; after NDIG shifts the LSB digit sits at bit 0.
  assign acc_next = WIDTH'({slice_s, acc} >> DIGIT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      op_a   <= '0;
      op_b   <= '0;
      acc    <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            op_a  <= a;
            op_b  <= sub ? ~b : b;
            carry <= sub;
            cnt   <= '0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        RUN: begin
          acc   <= acc_next;
          op_a  <= op_a >> DIGIT;
          op_b  <= op_b >> DIGIT;
          carry <= slice_cout;
          cnt   <= cnt + CW'(1);
          // Last digit: the slice's top-bit carry-in is the carry into the word MSB.
          if (cnt == CW'(NDIG - 1)) begin
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= acc_next;
            cout   <= slice_cout;
            ovf    <= slice_cout ^ slice_cmsb;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub across several WIDTH/DIGIT configurations.
module tb_serial_addsub;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic       start8, sub8, busy8, done8, cout8, ovf8;
  logic [7:0] a8, b8, r8;
  logic       start4, sub4, busy4, done4, cout4, ovf4;
  logic [7:0] a4, b4, r4;
  logic       startw, subw, busyw, donew, coutw, ovfw;
  logic [7:0] aw, bw, rw;
  logic        start16, sub16, busy16, done16, cout16, ovf16;
  logic [15:0] a16, b16, r16;

  serial_addsub #(.WIDTH(8), .DIGIT(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result(r8), .cout(cout8), .ovf(ovf8));
  serial_addsub #(.WIDTH(8), .DIGIT(4)) dut84 (
    .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .result(r4), .cout(cout4), .ovf(ovf4));
  serial_addsub #(.WIDTH(8), .DIGIT(8)) dut88 (
    .clk(clk), .rst_n(rst_n), .start(startw), .sub(subw), .a(aw), .b(bw),
    .busy(busyw), .done(donew), .result(rw), .cout(coutw), .ovf(ovfw));
  serial_addsub #(.WIDTH(16), .DIGIT(2)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .sub(sub16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .result(r16), .cout(cout16), .ovf(ovf16));

  // Reference: unsigned wrap for result, a >= b / sum overflow for carry, signed range for ovf.
  function automatic void ref_model(input int w, input logic [15:0] ia, input logic [15:0] ib,
                                    input logic is, output logic [15:0] r, output logic c,
                                    output logic o);
    int ua, ub, md, sum, sa, sb, sr;
    md = 1 << w;
    ua = int'(ia) & (md - 1);
    ub = int'(ib) & (md - 1);
    sa = (ua >= md / 2) ? ua - md : ua;
    sb = (ub >= md / 2) ? ub - md : ub;
    if (is) begin
      sum = ua - ub + md;
      c   = (ua >= ub);
      sr  = sa - sb;
    end else begin
      sum = ua + ub;
      c   = (sum >= md);
      sr  = sa + sb;
    end
    r = 16'(sum & (md - 1));
    o = (sr > md / 2 - 1) || (sr < -(md / 2));
  endfunction

  // One operation on the 8-bit / 1-bit-digit instance, with busy and latency checks.
  task automatic run8(input logic [7:0] ia, input logic [7:0] ib, input logic is, input string name);
    logic [15:0] er;
    logic        ec, eo;
    int          lat;
    ref_model(8, 16'(ia), 16'(ib), is, er, ec, eo);
    start8 = 1'b1; a8 = ia; b8 = ib; sub8 = is;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = ~ia; b8 = ~ib; sub8 = ~is;
    lat = 0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (done8) begin lat = n; break; end
      checks++;
      if (busy8 !== 1'b1) begin
        failures++; $display("FAIL %s busy cycle %0d: got %b want 1", name, n, busy8);
      end
    end
    checks++;
    if (lat !== 9) begin failures++; $display("FAIL %s latency: got %0d want 9", name, lat); end
    checks++;
    if (busy8 !== 1'b0) begin failures++; $display("FAIL %s busy at done: got %b want 0", name, busy8); end
    checks++;
    if ({r8, cout8, ovf8} !== {er[7:0], ec, eo}) begin
      failures++;
      $display("FAIL %s result/cout/ovf: got %h/%b/%b want %h/%b/%b", name, r8, cout8, ovf8, er[7:0], ec, eo);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy8, done8, r8, cout8, ovf8} !== 12'h0) begin
      failures++; $display("FAIL reset_dut8: got busy=%b done=%b r=%h c=%b o=%b want all 0", busy8, done8, r8, cout8, ovf8);
    end
    checks++;
    if ({busy4, done4, r4, cout4, ovf4, busyw, donew, rw, coutw, ovfw} !== 24'h0) begin
      failures++; $display("FAIL reset_dut8x: got r4=%h rw=%h busy=%b%b want 0", r4, rw, busy4, busyw);
    end
    checks++;
    if ({busy16, done16, r16, cout16, ovf16} !== 20'h0) begin
      failures++; $display("FAIL reset_dut16: got busy=%b r=%h want 0", busy16, r16);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add_sub();
    run8(8'h5A, 8'h3C, 1'b0, "add_5a_3c");
    run8(8'hFF, 8'h01, 1'b0, "add_wrap");
    run8(8'h10, 8'h20, 1'b1, "sub_borrow");
    run8(8'h80, 8'h01, 1'b1, "sub_ovf");
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat1, lat2;
    start8 = 1'b1; a8 = 8'h01; b8 = 8'h02; sub8 = 1'b0;
    @(posedge clk); #1;
    a8 = 8'h77;
    lat1 = 0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (done8) begin lat1 = n; break; end
    end
    checks++;
    if (lat1 !== 9) begin failures++; $display("FAIL b2b_first_latency: got %0d want 9", lat1); end
    checks++;
    if (r8 !== 8'h03) begin failures++; $display("FAIL b2b_first_result: got %h want 03", r8); end
    @(posedge clk); #1;
    start8 = 1'b0;
    lat2 = 0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (done8) begin lat2 = n; break; end
    end
    checks++;
    if (lat2 !== 9) begin failures++; $display("FAIL b2b_second_latency: got %0d want 9", lat2); end
    checks++;
    if (r8 !== 8'h79) begin failures++; $display("FAIL b2b_second_result: got %h want 79", r8); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int pulses;
    start8 = 1'b1; a8 = 8'h12; b8 = 8'h34; sub8 = 1'b0;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy8, done8, r8, cout8, ovf8} !== 12'h0) begin
      failures++; $display("FAIL reset_mid_outputs: got busy=%b done=%b r=%h c=%b o=%b want all 0", busy8, done8, r8, cout8, ovf8);
    end
    rst_n = 1'b1;
    pulses = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (done8 || busy8) pulses++;
    end
    checks++;
    if (pulses !== 0) begin failures++; $display("FAIL reset_mid_aborted: got %0d active cycles want 0", pulses); end
    run8(8'h12, 8'h34, 1'b0, "after_reset");
    @(negedge clk);
  endtask

  task automatic test_digit_widths();
    int l4, lw;
    start4 = 1'b1; a4 = 8'h5A; b4 = 8'h3C; sub4 = 1'b0;
    startw = 1'b1; aw = 8'h5A; bw = 8'h3C; subw = 1'b0;
    @(posedge clk); #1;
    start4 = 1'b0; startw = 1'b0; a4 = 8'h00; aw = 8'h00;
    l4 = 0; lw = 0;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      if (done4 && l4 == 0) l4 = n;
      if (donew && lw == 0) lw = n;
    end
    checks++;
    if (l4 !== 3) begin failures++; $display("FAIL digit4_latency: got %0d want 3", l4); end
    checks++;
    if (lw !== 2) begin failures++; $display("FAIL digit8_latency: got %0d want 2", lw); end
    checks++;
    if ({r4, cout4, ovf4} !== {8'h96, 1'b0, 1'b1}) begin
      failures++; $display("FAIL digit4_result: got %h/%b/%b want 96/0/1", r4, cout4, ovf4);
    end
    checks++;
    if ({rw, coutw, ovfw} !== {8'h96, 1'b0, 1'b1}) begin
      failures++; $display("FAIL digit8_result: got %h/%b/%b want 96/0/1", rw, coutw, ovfw);
    end
  endtask

  task automatic test_random();
    logic [15:0] ia, ib, er;
    logic        is, ec, eo;
    int          lat;
    for (int k = 0; k < 1000; k++) begin
      ia = 16'($urandom);
      ib = 16'($urandom);
      is = 1'($urandom);
      if (k < 4) begin ia = 16'h8000 + 16'(k); ib = 16'hFFFF - 16'(k); end
      ref_model(16, ia, ib, is, er, ec, eo);
      start16 = 1'b1; a16 = ia; b16 = ib; sub16 = is;
      @(posedge clk); #1;
      start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); sub16 = 1'($urandom);
      lat = 0;
      for (int n = 1; n <= 12; n++) begin
        @(negedge clk);
        if (done16) begin lat = n; break; end
      end
      checks++;
      if (lat !== 9) begin failures++; $display("FAIL rand%0d_latency: got %0d want 9", k, lat); end
      checks++;
      if (r16 !== er) begin failures++; $display("FAIL rand%0d_result: got %h want %h (a=%h b=%h sub=%b)", k, r16, er, ia, ib, is); end
      checks++;
      if (cout16 !== ec) begin failures++; $display("FAIL rand%0d_cout: got %b want %b", k, cout16, ec); end
      checks++;
      if (ovf16 !== eo) begin failures++; $display("FAIL rand%0d_ovf: got %b want %b", k, ovf16, eo); end
      if ($urandom_range(3) == 0) @(negedge clk);
    end
  endtask

  initial begin
    start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0;
    start4 = 1'b0; sub4 = 1'b0; a4 = '0; b4 = '0;
    startw = 1'b0; subw = 1'b0; aw = '0; bw = '0;
    start16 = 1'b0; sub16 = 1'b0; a16 = '0; b16 = '0;
    test_reset();
    test_add_sub();
    test_back_to_back();
    test_reset_mid();
    test_digit_widths();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
